// File: rtl/fir_prog_if.sv
// fir_prog_if: sample stream, coefficient write port and result bus
// of the programmable FIR filter.
interface fir_prog_if #(
    parameter int NB_INPUT  = 16,
    parameter int NB_COEF   = 16,
    parameter int NB_OUTPUT = 18,
    parameter int NB_ADDR   = 3
);
    logic                 i_valid;
    logic [NB_INPUT-1:0]  i_data;
    logic                 i_coef_we;
    logic [NB_ADDR-1:0]   i_coef_addr;
    logic [NB_COEF-1:0]   i_coef_data;
    logic                 i_coef_commit;
    logic                 o_valid;
    logic [NB_OUTPUT-1:0] o_data;
    logic                 o_overflow;

    modport master (
        output i_valid, i_data,
        output i_coef_we, i_coef_addr, i_coef_data, i_coef_commit,
        input  o_valid, o_data, o_overflow
    );

    modport slave (
        input  i_valid, i_data,
        input  i_coef_we, i_coef_addr, i_coef_data, i_coef_commit,
        output o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/fir_prog.sv
// fir_prog: runtime-programmable N-tap FIR with shadow/active coefficient
// banks. Define FIR_ROUND_EN for half-up product rounding (default: floor).
module fir_prog #(
    parameter int NB_INPUT  = 16,
    parameter int NB_COEF   = 16,
    parameter int NB_OUTPUT = 18,
    parameter int NTAPS     = 8,
    parameter int NB_ADDR   = $clog2(NTAPS)
) (
    input logic       i_clk,
    input logic       i_rst,
    fir_prog_if.slave bus
);
    localparam int NB_PROD = NB_INPUT + NB_COEF;
    localparam int NB_WIDE = NB_PROD + 1;
    localparam int SHIFT   = NB_COEF - 1;
    localparam int NB_SHR  = NB_WIDE - SHIFT;
    localparam int NB_TOPP = NB_SHR - NB_INPUT + 1;
    localparam int NB_TREE = NB_INPUT + $clog2(NTAPS);

    localparam logic [NB_INPUT-1:0] P_MAX = {1'b0, {(NB_INPUT-1){1'b1}}};
    localparam logic [NB_INPUT-1:0] P_MIN = {1'b1, {(NB_INPUT-1){1'b0}}};
    localparam logic [NB_OUTPUT-1:0] O_MAX = {1'b0, {(NB_OUTPUT-1){1'b1}}};
    localparam logic [NB_OUTPUT-1:0] O_MIN = {1'b1, {(NB_OUTPUT-1){1'b0}}};

`ifdef FIR_ROUND_EN
    localparam logic signed [NB_WIDE-1:0] RND = NB_WIDE'(1) << (NB_COEF - 2);
`endif

    logic signed [NB_INPUT-1:0] x           [NTAPS];
    logic signed [NB_COEF-1:0]  shadow      [NTAPS];
    logic signed [NB_COEF-1:0]  shadow_next [NTAPS];
    logic signed [NB_COEF-1:0]  active      [NTAPS];
    logic signed [NB_PROD-1:0]  mul         [NTAPS];
    logic signed [NB_WIDE-1:0]  wide        [NTAPS];
    logic signed [NB_SHR-1:0]   shr         [NTAPS];
    logic signed [NB_INPUT-1:0] prod        [NTAPS];
    logic signed [NB_INPUT-1:0] p           [NTAPS];
    logic                       x_valid;
    logic                       p_valid;
    logic signed [NB_TREE-1:0]  sum;
    logic [NB_OUTPUT-1:0]       sat;
    logic                       ovf;

    // delay line shifts on each accepted sample and holds otherwise
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= bus.i_valid;
            if (bus.i_valid) begin
                x[0] <= bus.i_data;
                for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            end
        end
    end

    // shadow bank with this cycle's write applied (commit sees it too)
    always_comb begin
        for (int k = 0; k < NTAPS; k++) shadow_next[k] = shadow[k];
        if (bus.i_coef_we && int'(bus.i_coef_addr) < NTAPS)
            shadow_next[bus.i_coef_addr] = bus.i_coef_data;
    end

    // coefficient banks: shadow takes writes, active loads on commit
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) shadow[k] <= shadow_next[k];
            if (bus.i_coef_commit)
                for (int k = 0; k < NTAPS; k++) active[k] <= shadow_next[k];
        end
    end

    // per-tap product, requantised to input format and saturated
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            mul[k]  = x[k] * active[k];
            wide[k] = NB_WIDE'(mul[k]);
`ifdef FIR_ROUND_EN
            wide[k] = wide[k] + RND;
`endif
            shr[k]  = NB_SHR'(wide[k] >>> SHIFT);
            if (shr[k][NB_SHR-1 -: NB_TOPP] == {NB_TOPP{shr[k][NB_SHR-1]}})
                prod[k] = shr[k][NB_INPUT-1:0];
            else
                prod[k] = shr[k][NB_SHR-1] ? P_MIN : P_MAX;
        end
    end

    // product register loads only after a delay-line shift
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < NTAPS; k++) p[k] <= '0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= x_valid;
            if (x_valid)
                for (int k = 0; k < NTAPS; k++) p[k] <= prod[k];
        end
    end

    // full-width adder tree; cannot overflow at NB_TREE bits
    always_comb begin
        sum = '0;
        for (int k = 0; k < NTAPS; k++) sum = sum + NB_TREE'(p[k]);
    end

    if (NB_OUTPUT >= NB_TREE) begin : g_ext
        // output is wide enough: sign-extend, never overflows
        always_comb begin
            sat = NB_OUTPUT'(sum);
            ovf = 1'b0;
        end
    end else begin : g_sat
        localparam int NB_TOPS = NB_TREE - NB_OUTPUT + 1;
        // clamp the tree sum into the output range
        always_comb begin
            sat = sum[NB_OUTPUT-1:0];
            ovf = 1'b0;
            if (sum[NB_TREE-1 -: NB_TOPS] != {NB_TOPS{sum[NB_TREE-1]}}) begin
                ovf = 1'b1;
                sat = sum[NB_TREE-1] ? O_MIN : O_MAX;
            end
        end
    end

    // output register: one-cycle valid pulse, data held between pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_overflow <= 1'b0;
        end else begin
            bus.o_valid <= p_valid;
            if (p_valid) begin
                bus.o_data     <= sat;
                bus.o_overflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_fir_prog.sv
// tb_fir_prog: scoreboard bench for fir_prog, an 8-tap and a 2-tap
// instance driven with directed vectors and hand-computed results.
module tb_fir_prog;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [17:0] data;
        logic        ov;
        int          at;
    } exp_t;

    exp_t        q8[$];
    exp_t        q2[$];
    logic [17:0] last8 = '0;
    logic [17:0] last2 = '0;
    logic        lov8 = 1'b0;
    logic        lov2 = 1'b0;

`ifdef FIR_ROUND_EN
    localparam logic [17:0] RND_POS = 18'h00001;
    localparam logic [17:0] RND_NEG = 18'h00000;
`else
    localparam logic [17:0] RND_POS = 18'h00000;
    localparam logic [17:0] RND_NEG = 18'h3FFFF;
`endif

    // impulse 0x4000 through taps 0x1000*(k+1); 0x8000 is -1.0
    logic [17:0] imp_tab [9] = '{18'h00800, 18'h01000, 18'h01800,
        18'h02000, 18'h02800, 18'h03000, 18'h03800, 18'h3C000, 18'h00000};
    logic [17:0] pos_tab [8] = '{18'h07FFE, 18'h0FFFC, 18'h17FFA,
        18'h1FFF8, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF};
    logic        pos_ov  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [17:0] neg_tab [8] = '{18'h1FFFF, 18'h1FFF6, 18'h0FFF9,
        18'h3FFFC, 18'h2FFFF, 18'h20002, 18'h20000, 18'h20000};
    logic        neg_ov  [8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    // 0x4000 filling a line of 0x8000 samples, all taps 0x1000
    logic [17:0] mix_tab [8] = '{18'h39800, 18'h3B000, 18'h3C800,
        18'h3E000, 18'h3F800, 18'h01000, 18'h02800, 18'h04000};

    fir_prog_if #(.NB_ADDR(3)) bus8 ();
    fir_prog_if #(.NB_ADDR(1)) bus2 ();

    fir_prog #(.NTAPS(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8.slave)
    );

    fir_prog #(.NTAPS(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor for the 8-tap instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last8 = '0;
            lov8  = 1'b0;
        end else if (bus8.o_valid) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL dut8_unexpected_valid actual=%h required=none",
                         bus8.o_data);
            end else begin
                e = q8.pop_front();
                last8 = e.data;
                lov8  = e.ov;
                if (bus8.o_data !== e.data || bus8.o_overflow !== e.ov ||
                    cyc != e.at + 3) begin
                    failures++;
                    $display("FAIL dut8_result actual=%h/%b@%0d required=%h/%b@%0d",
                             bus8.o_data, bus8.o_overflow, cyc,
                             e.data, e.ov, e.at + 3);
                end
            end
        end else begin
            checks++;
            if (bus8.o_data !== last8 || bus8.o_overflow !== lov8) begin
                failures++;
                $display("FAIL dut8_hold actual=%h/%b required=%h/%b",
                         bus8.o_data, bus8.o_overflow, last8, lov8);
            end
        end
    end

    // monitor for the 2-tap instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last2 = '0;
            lov2  = 1'b0;
        end else if (bus2.o_valid) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL dut2_unexpected_valid actual=%h required=none",
                         bus2.o_data);
            end else begin
                e = q2.pop_front();
                last2 = e.data;
                lov2  = e.ov;
                if (bus2.o_data !== e.data || bus2.o_overflow !== e.ov ||
                    cyc != e.at + 3) begin
                    failures++;
                    $display("FAIL dut2_result actual=%h/%b@%0d required=%h/%b@%0d",
                             bus2.o_data, bus2.o_overflow, cyc,
                             e.data, e.ov, e.at + 3);
                end
            end
        end else begin
            checks++;
            if (bus2.o_data !== last2 || bus2.o_overflow !== lov2) begin
                failures++;
                $display("FAIL dut2_hold actual=%h/%b required=%h/%b",
                         bus2.o_data, bus2.o_overflow, last2, lov2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send8(input logic [15:0] d, input logic [17:0] e,
                         input logic ov);
        bus8.i_valid = 1'b1;
        bus8.i_data  = d;
        q8.push_back('{data: e, ov: ov, at: cyc});
        tick();
        bus8.i_valid = 1'b0;
    endtask

    task automatic send2(input logic [15:0] d, input logic [17:0] e,
                         input logic ov);
        bus2.i_valid = 1'b1;
        bus2.i_data  = d;
        q2.push_back('{data: e, ov: ov, at: cyc});
        tick();
        bus2.i_valid = 1'b0;
    endtask

    task automatic wr8(input logic [2:0] a, input logic [15:0] c,
                       input logic commit);
        bus8.i_coef_we     = 1'b1;
        bus8.i_coef_addr   = a;
        bus8.i_coef_data   = c;
        bus8.i_coef_commit = commit;
        tick();
        bus8.i_coef_we     = 1'b0;
        bus8.i_coef_commit = 1'b0;
    endtask

    task automatic wr2(input logic a, input logic [15:0] c,
                       input logic commit);
        bus2.i_coef_we     = 1'b1;
        bus2.i_coef_addr   = a;
        bus2.i_coef_data   = c;
        bus2.i_coef_commit = commit;
        tick();
        bus2.i_coef_we     = 1'b0;
        bus2.i_coef_commit = 1'b0;
    endtask

    task automatic fill8(input logic [15:0] c, input logic commit);
        for (int k = 0; k < 8; k++) wr8(3'(k), c, commit && k == 7);
    endtask

    initial begin
        bus8.i_valid = 1'b1;
        bus8.i_data = 16'h7FFF;
        bus8.i_coef_we = 1'b0;
        bus8.i_coef_addr = '0;
        bus8.i_coef_data = '0;
        bus8.i_coef_commit = 1'b0;
        bus2.i_valid = 1'b1;
        bus2.i_data = 16'h7FFF;
        bus2.i_coef_we = 1'b0;
        bus2.i_coef_addr = '0;
        bus2.i_coef_data = '0;
        bus2.i_coef_commit = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rst_dut8", {13'd0, bus8.o_valid, bus8.o_data},
                32'd0 | {14'd0, bus8.o_overflow, 17'd0});
            chk("rst_dut8_ovf", 32'(bus8.o_overflow), 32'd0);
            chk("rst_dut2", {13'd0, bus2.o_valid, bus2.o_data}, 32'd0);
            chk("rst_dut2_ovf", 32'(bus2.o_overflow), 32'd0);
        end
        bus8.i_valid = 1'b0;
        bus2.i_valid = 1'b0;
        rst = 1'b1;
        tick();

        wr2(1'b0, 16'h8000, 1'b0);
        wr2(1'b1, 16'h0000, 1'b1);
        send2(16'h8000, 18'h07FFF, 1'b0);
        send2(16'h8000, 18'h07FFF, 1'b0);
        wr2(1'b1, 16'h8000, 1'b1);
        send2(16'h8000, 18'h0FFFE, 1'b0);
        wr2(1'b0, 16'h4000, 1'b0);
        wr2(1'b1, 16'h0000, 1'b1);
        send2(16'h0001, RND_POS, 1'b0);
        send2(16'hFFFF, RND_NEG, 1'b0);
        idle(5);

        for (int k = 0; k < 8; k++)
            wr8(3'(k), 16'(16'h1000 * (k + 1)), k == 7);
        for (int i = 0; i < 9; i++)
            send8(i == 0 ? 16'h4000 : 16'h0000, imp_tab[i], 1'b0);
        idle(4);
        for (int i = 0; i < 9; i++) begin
            send8(i == 0 ? 16'h4000 : 16'h0000, imp_tab[i], 1'b0);
            idle(2);
        end

        fill8(16'h7FFF, 1'b1);
        for (int i = 0; i < 8; i++) send8(16'h7FFF, pos_tab[i], pos_ov[i]);
        for (int i = 0; i < 8; i++) send8(16'h8000, neg_tab[i], neg_ov[i]);

        fill8(16'h1000, 1'b1);
        for (int i = 0; i < 8; i++) send8(16'h4000, mix_tab[i], 1'b0);
        fill8(16'h2000, 1'b0);
        send8(16'h4000, 18'h04000, 1'b0);
        send8(16'h4000, 18'h04000, 1'b0);
        bus8.i_coef_commit = 1'b1;
        send8(16'h4000, 18'h08000, 1'b0);
        bus8.i_coef_commit = 1'b0;
        send8(16'h4000, 18'h08000, 1'b0);
        idle(5);

        send8(16'h4000, 18'h08000, 1'b0);
        send8(16'h4000, 18'h08000, 1'b0);
        rst = 1'b0;
        q8.delete();
        q2.delete();
        idle(2);
        rst = 1'b1;
        idle(5);
        send8(16'h4000, 18'h00000, 1'b0);

        for (int i = 0; i < 20 && (q8.size() != 0 || q2.size() != 0); i++)
            tick();
        chk("q8_drained", q8.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
